// File: rtl/sdu_uart_rx.sv
// sdu_uart_rx: 8N1 serial receiver with majority-vote mid-bit sampling and a FWFT byte FIFO.
// Ports:
//   clk       oversample clock (OVS x baud)
//   rst       asynchronous active-high reset
//   rxd       raw serial line, idle high
//   rx_data   FIFO head byte, zero while rx_valid is low
//   rx_valid  FIFO not empty
//   rx_ready  consumer accepts head byte when rx_valid is high
//   frame_err one-cycle pulse when a stop bit is sampled low
//   overrun   one-cycle pulse when a good byte is dropped on a full FIFO
//   fifo_cnt  occupied FIFO entries
module sdu_uart_rx #(
    parameter int OVS         = 16,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rxd,
    output logic [DATA_BITS-1:0]              rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic                              frame_err,
    output logic                              overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt
);
    localparam int NW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [NW-1:0] N_S0   = NW'(OVS / 2 - 1);
    localparam logic [NW-1:0] N_S1   = NW'(OVS / 2);
    localparam logic [NW-1:0] N_DEC  = NW'(OVS / 2 + 1);
    localparam logic [NW-1:0] N_LAST = NW'(OVS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW-1:0] A_LAST = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t                 r_state, w_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [NW-1:0]          r_cnt, w_cnt_nxt;
    logic [BW-1:0]          r_bit;
    logic                   r_s0, r_s1;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wp, r_rp;
    logic [CW-1:0]          r_fcnt;
    logic                   w_srx, w_maj, w_dec, w_end;
    logic                   w_push_req, w_ferr, w_pop, w_full, w_push;

    assign w_srx = r_sync[SYNC_STAGES-1];
    // third vote is the live sample at the decision cycle
    assign w_maj = (r_s0 & r_s1) | (r_s0 & w_srx) | (r_s1 & w_srx);
    assign w_dec = r_cnt == N_DEC;
    assign w_end = r_cnt == N_LAST;

    // the IDLE cycle that first sees srx low is cnt=0, so START begins at 1
    assign w_cnt_nxt = (w_nxt == S_IDLE || w_nxt == S_BREAK) ? '0 :
                       (r_state == S_IDLE) ? NW'(1) :
                       w_end ? '0 : r_cnt + NW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_srx) w_nxt = S_START;
            S_START: if (w_dec && w_maj) w_nxt = S_IDLE;
                     else if (w_end) w_nxt = S_DATA;
            S_DATA:  if (w_end && r_bit == B_LAST) w_nxt = S_STOP;
            S_STOP:  if (w_dec) w_nxt = w_maj ? S_IDLE : S_BREAK;
            S_BREAK: if (w_srx) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_push_req = r_state == S_STOP && w_dec && w_maj;
        w_ferr     = r_state == S_STOP && w_dec && !w_maj;
    end

    assign w_pop    = rx_valid && rx_ready;
    assign w_full   = r_fcnt == C_FULL;
    // a pop in the same cycle frees the slot the push needs
    assign w_push   = w_push_req && (!w_full || w_pop);
    assign rx_valid = r_fcnt != '0;
    assign rx_data  = rx_valid ? r_mem[r_rp] : '0;
    assign fifo_cnt = r_fcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= '1;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_shift   <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_fcnt    <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_cnt     <= w_cnt_nxt;
            if (r_cnt == N_S0) r_s0 <= w_srx;
            if (r_cnt == N_S1) r_s1 <= w_srx;
            if (r_state == S_START && w_end) r_bit <= '0;
            else if (r_state == S_DATA && w_end) r_bit <= r_bit + BW'(1);
            if (r_state == S_DATA && w_dec) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            frame_err <= w_ferr;
            overrun   <= w_push_req && w_full && !w_pop;
            if (w_push) r_wp <= (r_wp == A_LAST) ? '0 : r_wp + AW'(1);
            if (w_pop)  r_rp <= (r_rp == A_LAST) ? '0 : r_rp + AW'(1);
            r_fcnt    <= r_fcnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= r_shift;
    end
endmodule

// File: tb/tb_sdu_uart_rx.sv
// tb_sdu_uart_rx: table-driven and hand-sequenced checks of sdu_uart_rx at default parameters.
module tb_sdu_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;
    logic [2:0] fifo_cnt;

    sdu_uart_rx dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    int         nvec = 0, nerr = 0;
    int         cyc = 0, rise_cyc = 0, ferr_n = 0, ovr_n = 0;
    logic       prev_v = 1'b0;
    logic [7:0] popq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) popq.push_back(rx_data);
        if (frame_err) ferr_n++;
        if (overrun) ovr_n++;
        if (rx_valid && !prev_v) rise_cyc = cyc;
        prev_v = rx_valid;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         brk;
        int         exp_pops;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(d[i], 16);
        hold(stop, 16);
    endtask

    task automatic drain_chk(input string nm, input int q0, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_b [4];
        exp_b = '{e0, e1, e2, e3};
        rx_ready = 1'b1;
        hold(1'b1, 8);
        rx_ready = 1'b0;
        chk({nm, "_pops"}, popq.size() - q0, 4);
        for (int k = 0; k < 4; k++)
            if (popq.size() > q0 + k) chk($sformatf("%s_byte%0d", nm, k), popq[q0 + k], exp_b[k]);
        chk({nm, "_valid_after"}, rx_valid, 0);
    endtask

    initial begin
        int q0, f0, o0, t0, lat;
        tbl[0] = '{8'h55, 1'b1, 0, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 0, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, 0, 1, 0};
        tbl[3] = '{8'hA3, 1'b0, 40, 0, 1};
        tbl[4] = '{8'h3C, 1'b1, 0, 1, 0};
        tbl[5] = '{8'h80, 1'b1, 0, 1, 0};

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_cnt", fifo_cnt, 0);
        rst = 1'b0;
        hold(1'b1, 10);

        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            q0 = popq.size();
            f0 = ferr_n;
            o0 = ovr_n;
            t0 = cyc;
            send(tbl[i].d, tbl[i].stop);
            hold(1'b0, tbl[i].brk);
            hold(1'b1, 24);
            chk($sformatf("v%0d_pops", i), popq.size() - q0, tbl[i].exp_pops);
            if (tbl[i].exp_pops == 1 && popq.size() > q0) chk($sformatf("v%0d_data", i), popq[q0], tbl[i].d);
            chk($sformatf("v%0d_ferr", i), ferr_n - f0, tbl[i].exp_ferr);
            chk($sformatf("v%0d_ovr", i), ovr_n - o0, 0);
            chk($sformatf("v%0d_cnt", i), fifo_cnt, 0);
            if (tbl[i].exp_pops == 1) begin
                nvec++;
                lat = rise_cyc - t0;
                if (lat < 155 || lat > 157) begin
                    nerr++;
                    $display("FAIL v%0d_latency: got %0d cycles, want 156 +/-1", i, lat);
                end
            end
        end

        q0 = popq.size();
        hold(1'b0, 4);
        hold(1'b1, 30);
        chk("glitch_pops", popq.size() - q0, 0);
        chk("glitch_cnt", fifo_cnt, 0);
        send(8'hA7, 1'b1);
        hold(1'b1, 8);
        chk("glitch_next_pops", popq.size() - q0, 1);
        if (popq.size() > q0) chk("glitch_next_data", popq[q0], 8'hA7);

        rx_ready = 1'b0;
        q0 = popq.size();
        o0 = ovr_n;
        f0 = ferr_n;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        hold(1'b1, 20);
        chk("ovr_cnt", fifo_cnt, 4);
        chk("ovr_pulses", ovr_n - o0, 1);
        chk("ovr_ferr", ferr_n - f0, 0);
        chk("ovr_head", rx_data, 8'h01);
        drain_chk("ovr_drain", q0, 8'h01, 8'h02, 8'h03, 8'h04);

        q0 = popq.size();
        o0 = ovr_n;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        send(8'h44, 1'b1);
        hold(1'b1, 4);
        chk("full_cnt", fifo_cnt, 4);
        fork
            send(8'h99, 1'b1);
            begin
                repeat (155) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        hold(1'b1, 4);
        chk("simul_ovr", ovr_n - o0, 0);
        chk("simul_cnt", fifo_cnt, 4);
        chk("simul_pop1", popq.size() - q0, 1);
        if (popq.size() > q0) chk("simul_pop1_data", popq[q0], 8'h11);
        drain_chk("simul_drain", q0 + 1, 8'h22, 8'h33, 8'h44, 8'h99);

        send(8'hAA, 1'b1);
        send(8'hBB, 1'b1);
        hold(1'b1, 4);
        chk("pre_rst_cnt", fifo_cnt, 2);
        q0 = popq.size();
        f0 = ferr_n;
        hold(1'b0, 16 + 48 + 8);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_data", rx_data, 0);
        chk("mid_rst_cnt", fifo_cnt, 0);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_ovr", overrun, 0);
        hold(1'b0, 8);
        hold(1'b1, 4);
        rst = 1'b0;
        hold(1'b1, 12 + 64 + 30);
        chk("post_rst_cnt", fifo_cnt, 0);
        chk("post_rst_ferr", ferr_n - f0, 0);
        rx_ready = 1'b1;
        send(8'h12, 1'b1);
        hold(1'b1, 8);
        chk("post_rst_pops", popq.size() - q0, 1);
        if (popq.size() > q0) chk("post_rst_data", popq[q0], 8'h12);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
